// File: rtl/memory_responder_if.sv
// Processor/loader memory port bundle for memory_responder.
// master = processor + loader side, slave = responder.
interface memory_responder_if;
  logic       mem_en;
  logic       mem_read;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       busy;
  logic       load_we;
  logic [6:0] load_addr;
  logic [7:0] load_data;
  logic       load_ack;

  modport master (
    output mem_en, mem_read, mem_addr, mem_wdata, load_we, load_addr, load_data,
    input  mem_rdata, mem_ready, busy, load_ack
  );

  modport slave (
    input  mem_en, mem_read, mem_addr, mem_wdata, load_we, load_addr, load_data,
    output mem_rdata, mem_ready, busy, load_ack
  );
endinterface

// File: rtl/memory_responder.sv
// 128x8 RAM responder: accepts one request at a time, pulses mem_ready
// LATENCY cycles after acceptance; side loader writes only when fully idle.
module memory_responder #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DEPTH   = 128
) (
  input logic          clk,
  input logic          rst_n,
  memory_responder_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] addr_q, addr_d;
  logic       read_q, read_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       load_ack_q, load_ack_d;

  logic [7:0] ram [DEPTH];
  logic       enter_resp;
  logic       ram_we;
  logic [6:0] ram_waddr;
  logic [7:0] ram_wdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    read_d     = read_q;
    wdata_d    = wdata_q;
    rdata_d    = 8'h00;
    load_ack_d = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_en) begin
          addr_d  = bus.mem_addr;
          read_d  = bus.mem_read;
          wdata_d = bus.mem_wdata;
          cnt_d   = LAT;
          if (LAT == 4'd0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          load_ack_d = bus.load_we;
        end
      end
      S_WAIT: begin
        cnt_d = 4'(cnt_q - 4'd1);
        if (cnt_q <= 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // addr_d/read_d/wdata_d already carry the live request when LATENCY=0
    if (enter_resp && read_d) rdata_d = ram[addr_d];

    ram_we    = 1'b0;
    ram_waddr = addr_d;
    ram_wdata = wdata_d;
    if (enter_resp && !read_d) begin
      ram_we = 1'b1;
    end else if (load_ack_d) begin
      ram_we    = 1'b1;
      ram_waddr = bus.load_addr;
      ram_wdata = bus.load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 7'd0;
      read_q     <= 1'b0;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      load_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      load_ack_q <= load_ack_d;
    end
  end

  // RAM is not reset; the rst_n gate drops any write racing an active reset
  always_ff @(posedge clk) begin
    if (ram_we && rst_n) ram[ram_waddr] <= ram_wdata;
  end

  assign bus.mem_ready = (state_q == S_RESP);
  assign bus.mem_rdata = rdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.load_ack  = load_ack_q;
endmodule
